// File: rtl/ctrl_valor_pkg.sv
// Shared constants for ctrl_valor: default timing parameters, repeat-FSM encodings
// and a sizing helper used for the timers.
package ctrl_valor_pkg;

    localparam int DEB_CYCLES_DEF   = 500000;
    localparam int REPEAT_DELAY_DEF = 25000000;
    localparam int REPEAT_RATE_DEF  = 5000000;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ctrl_valor_debouncer.sv
// One button: 2-flop synchronizer, stability counter and debounced level.
// press is a registered pulse in the first cycle the debounced level reads 1.
module ctrl_valor_debouncer
    import ctrl_valor_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            press <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            press <= 1'b0;
            // cnt holds how many consecutive samples have disagreed with level
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                level <= sync2;
                press <= sync2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/ctrl_valor.sv
// Up/down/clear push-button controlled 8-bit value with hold-to-repeat.
// A step lands on valor one edge after its press/repeat event; cambio flags it.
module ctrl_valor
    import ctrl_valor_pkg::*;
#(
    parameter int DEB_CYCLES   = DEB_CYCLES_DEF,
    parameter int REPEAT_DELAY = REPEAT_DELAY_DEF,
    parameter int REPEAT_RATE  = REPEAT_RATE_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_clr,
    output logic [7:0] valor,
    output logic       cambio
);

    localparam int TW = $clog2(max2(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [TW-1:0] DLY_LAST  = TW'(REPEAT_DELAY - 1);
    localparam logic [TW-1:0] RATE_LAST = TW'(REPEAT_RATE - 1);

    logic lvl_up, lvl_dn, lvl_clr;
    logic pr_up, pr_dn, pr_clr;

    ctrl_valor_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_up (
        .clk(clk), .rst(rst), .btn(btn_up), .level(lvl_up), .press(pr_up)
    );
    ctrl_valor_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_dn (
        .clk(clk), .rst(rst), .btn(btn_down), .level(lvl_dn), .press(pr_dn)
    );
    ctrl_valor_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb_clr (
        .clk(clk), .rst(rst), .btn(btn_clr), .level(lvl_clr), .press(pr_clr)
    );

    logic [1:0]    state, state_nx;
    logic [TW-1:0] timer, timer_nx;
    logic          dir, dir_nx;
    logic          step;
    logic          both;
    logic          held;

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        dir_nx   = dir;
        step     = 1'b0;
        both     = lvl_up & lvl_dn;
        held     = dir ? lvl_up : lvl_dn;
        case (state)
            ST_IDLE: begin
                if (!pr_clr && !both && (pr_up || pr_dn)) begin
                    step     = 1'b1;
                    dir_nx   = pr_up;
                    timer_nx = '0;
                    state_nx = ST_DELAY;
                end
            end
            ST_DELAY: begin
                // opposite-button presses only matter through 'both'
                if (pr_clr || both || !held) begin
                    timer_nx = '0;
                    state_nx = ST_IDLE;
                end else if (timer == DLY_LAST) begin
                    step     = 1'b1;
                    timer_nx = '0;
                    state_nx = ST_REPEAT;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            ST_REPEAT: begin
                if (pr_clr || both || !held) begin
                    timer_nx = '0;
                    state_nx = ST_IDLE;
                end else if (timer == RATE_LAST) begin
                    step     = 1'b1;
                    timer_nx = '0;
                end else begin
                    timer_nx = timer + 1'b1;
                end
            end
            default: begin
                timer_nx = '0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            timer <= '0;
            dir   <= 1'b0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            dir   <= dir_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valor  <= 8'd0;
            cambio <= 1'b0;
        end else begin
            cambio <= 1'b0;
            if (pr_clr) begin
                valor  <= 8'd0;
                cambio <= (valor != 8'd0);
            end else if (step) begin
                // saturating ends leave valor and cambio untouched
                if (dir_nx && valor != 8'hFF) begin
                    valor  <= valor + 8'd1;
                    cambio <= 1'b1;
                end else if (!dir_nx && valor != 8'd0) begin
                    valor  <= valor - 8'd1;
                    cambio <= 1'b1;
                end
            end
        end
    end

endmodule
